cnn_mul_sched: RTL
==================

CNN_MUL_SCHED -- requirements
Module: cnn_mul_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the multiplier.
REQ-002 SHALL have parameter A_WIDTH, default 14: signed multiplicand width.
REQ-003 SHALL have parameter B_WIDTH, default 8: unsigned multiplier width.
REQ-004 SHALL have parameter P_WIDTH, default 22: signed product width, equal to A_WIDTH+B_WIDTH.
REQ-005 SHALL have ports as follows (clock and reset first):
- ap_clk, input, 1: single clock; all state updates on its rising edge.
- ap_rst, input, 1: reset, synchronous, active-high.
- req_valid, input, NUM_REQ: per-requester operand valid.
- req_ready, output, NUM_REQ: per-requester accept; one-hot or zero.
- req_a, input, NUM_REQ*A_WIDTH: signed operands; requester i occupies bits [i*A_WIDTH +: A_WIDTH].
- req_b, input, NUM_REQ*B_WIDTH: unsigned operands, packed the same way.
- rsp_valid, output, 1: product valid.
- rsp_ready, input, 1: consumer accepts the product.
- rsp_id, output, clog2(NUM_REQ): index of the requester that owns rsp_p.
- rsp_p, output, P_WIDTH: signed product.
- idle, output, 1: high when no operation is in flight.

Function
REQ-006 SHALL arbitrate one shared A_WIDTH x B_WIDTH multiplier among NUM_REQ requesters using round-robin.
REQ-007 SHALL perform the handshake on each side as a valid/ready transfer. A transfer occurs in a cycle where both valid and ready are high.
REQ-008 SHALL compute the product as signed(a) * signed({1'b0,b}). B is zero-extended and never sign-interpreted. The full P_WIDTH result is kept with no truncation or saturation.
REQ-009 SHALL be a two-stage pipeline:
- S1: operand register holding valid, id, a, b.
- S2: product/output register driving rsp_valid, rsp_id, rsp_p.
REQ-010 SHALL define advance = !rsp_valid || rsp_ready.
- When advance is high, S2 loads S1 and S1 loads the granted request, or becomes invalid if there is no grant.
- When advance is low, both stages hold.
REQ-011 SHALL drive req_ready[i] = advance AND grant[i]. The grant is computed combinationally from req_valid and the priority pointer.
REQ-012 SHALL give priority in the order ptr, ptr+1, ... ptr+NUM_REQ-1, with the index wrapping modulo NUM_REQ.
REQ-013 SHALL update ptr to (g+1) mod NUM_REQ on acceptance of requester g. Without an acceptance, ptr SHALL be unchanged; this includes stall cycles.
REQ-014 SHALL raise rsp_valid exactly two rising edges after the accepting edge when rsp_ready stays high.
REQ-015 SHALL sustain throughput of one operation per cycle under continuous rsp_ready.
REQ-016 SHALL keep rsp_valid, rsp_id and rsp_p stable while rsp_valid && !rsp_ready.
REQ-017 SHALL, when S2 is full and stalled, let S1 hold its content and accept no new request. No operation is lost or duplicated.
REQ-018 SHALL, when S2 empties and S1 refills in the same cycle, perform both transfers.
REQ-019 SHALL deliver responses in acceptance order.
REQ-020 SHALL assert idle exactly when both S1 and S2 are invalid.
REQ-021 SHALL ignore req_a and req_b of any requester that is not granted.

Reset
REQ-022 SHALL, while ap_rst is high at a rising edge, clear S1/S2 valid, set ptr=0, rsp_valid=0, rsp_id=0, rsp_p=0 and idle=1.
REQ-023 SHALL drive req_ready all zero combinationally while ap_rst is high.
REQ-024 SHALL discard in-flight operations on reset mid-operation, producing no response for them after reset.

Structure
REQ-025 SHALL place the shared constants in package cnn_mul_sched_pkg:
- NUM_REQ, A_WIDTH, B_WIDTH, P_WIDTH defaults.
- ID_WIDTH = clog2(NUM_REQ).
REQ-026 SHALL implement the grant/pointer logic in one sub-module cnn_mul_rr_arb. Its ports are req, advance and grant, and it contains the ptr register.
REQ-027 SHALL instantiate the multiply as a single combinational product between S1 and S2, suitable for DSP inference.

Verification
REQ-028 Single request: req 1, a=-8192, b=255, rsp_ready=1. Required: rsp_valid two edges later with rsp_id=1, rsp_p=-2088960, and idle returns to 1.
REQ-029 Extremes: a=8191, b=255 gives rsp_p=2088705; a=-1, b=0 gives 0; a=-1, b=128 gives -128.
REQ-030 All four requesting continuously, ptr=0 after reset. Required: grants 0,1,2,3,0,1,... one per cycle, with matching rsp_id sequence and products.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles with two operations accepted. Required:
- rsp held stable.
- req_ready=0 during the stall.
- both results delivered in order after rsp_ready=1.
- ptr unchanged during the stall.
REQ-032 Reset mid-operation: ap_rst pulsed one cycle with S1 and S2 full. Required: rsp_valid=0 next cycle, no stale response, next grant goes to requester 0.
REQ-033 Sparse requests: only req 2 then req 0 valid, back-to-back. Required: grant 2 then 0, with ptr values 3 then 1.

Source files
------------

// File: rtl/cnn_mul_sched_pkg.sv
// cnn_mul_sched_pkg: shared default constants for the multiplier scheduler.
//   NUM_REQ  - requesters sharing one multiplier
//   A_WIDTH  - signed multiplicand width
//   B_WIDTH  - unsigned multiplier width (zero-extended before the multiply)
//   P_WIDTH  - signed product width, A_WIDTH+B_WIDTH
//   ID_WIDTH - requester index width
package cnn_mul_sched_pkg;
  localparam int NUM_REQ  = 4;
  localparam int A_WIDTH  = 14;
  localparam int B_WIDTH  = 8;
  localparam int P_WIDTH  = A_WIDTH + B_WIDTH;
  localparam int ID_WIDTH = $clog2(NUM_REQ);
endpackage

// File: rtl/cnn_mul_sched_if.sv
// cnn_mul_sched_if: request/response bundle of the multiplier scheduler.
//   req_valid/req_ready/req_a/req_b - per-requester operand handshake,
//                                     requester i at [i*W +: W]
//   rsp_valid/rsp_ready/rsp_id/rsp_p - product handshake
//   idle                             - no operation in flight
// master: requesters + consumer side; slave: the scheduler.
interface cnn_mul_sched_if #(
  parameter int NUM_REQ = cnn_mul_sched_pkg::NUM_REQ,
  parameter int A_WIDTH = cnn_mul_sched_pkg::A_WIDTH,
  parameter int B_WIDTH = cnn_mul_sched_pkg::B_WIDTH,
  parameter int P_WIDTH = cnn_mul_sched_pkg::P_WIDTH
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_WIDTH-1:0]        rsp_id;
  logic [P_WIDTH-1:0]         rsp_p;
  logic                       idle;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p, idle
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p, idle
  );
endinterface

// File: rtl/cnn_mul_rr_arb.sv
// cnn_mul_rr_arb: round-robin grant with a registered priority pointer.
//   ap_clk, ap_rst - clock, synchronous active-high reset (ptr -> 0)
//   req            - request vector (already masked by caller during reset)
//   advance        - pipeline can take a new operand this cycle
//   grant          - one-hot or zero, combinational from req and ptr
// ptr moves to one past the granted index only when the grant is taken
// (advance high); stall cycles leave it untouched.
module cnn_mul_rr_arb
  import cnn_mul_sched_pkg::*;
#(
  parameter int NUM_REQ = cnn_mul_sched_pkg::NUM_REQ
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] gidx;
  logic [ID_WIDTH-1:0] idxw;
  logic                hit;
  int                  idx;

  // Scan ptr, ptr+1, ... wrapping; first asserted request wins.
  always_comb begin
    grant = '0;
    gidx  = ptr;
    hit   = 1'b0;
    idx   = 0;
    idxw  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx  = (int'(ptr) + k) % NUM_REQ;
      idxw = ID_WIDTH'(idx);
      if (!hit && req[idxw]) begin
        hit         = 1'b1;
        grant[idxw] = 1'b1;
        gidx        = idxw;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst)
      ptr <= '0;
    else if (advance && hit)
      ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
  end
endmodule

// File: rtl/cnn_mul_sched.sv
// cnn_mul_sched: NUM_REQ requesters share one signed A x unsigned B multiplier.
//   ap_clk, ap_rst - clock, synchronous active-high reset
//   bus (slave)    - request side req_valid/req_ready/req_a/req_b,
//                    response side rsp_valid/rsp_ready/rsp_id/rsp_p, idle
// Two stages: S1 holds the granted operands, S2 holds the product. Both move
// together on advance = !rsp_valid || rsp_ready and hold otherwise, so a stalled
// S2 freezes S1 and blocks new grants; nothing is dropped or duplicated.
module cnn_mul_sched
  import cnn_mul_sched_pkg::*;
#(
  parameter int NUM_REQ = cnn_mul_sched_pkg::NUM_REQ,
  parameter int A_WIDTH = cnn_mul_sched_pkg::A_WIDTH,
  parameter int B_WIDTH = cnn_mul_sched_pkg::B_WIDTH,
  parameter int P_WIDTH = cnn_mul_sched_pkg::P_WIDTH
) (
  input  logic            ap_clk,
  input  logic            ap_rst,
  cnn_mul_sched_if.slave  bus
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);
  localparam int STAGES   = 2;

  logic                       advance;
  logic [NUM_REQ-1:0]         req_m;
  logic [NUM_REQ-1:0]         grant;
  logic [ID_WIDTH-1:0]        gidx;
  logic [STAGES:1]            vld_pipe;
  logic [ID_WIDTH-1:0]        s1_id;
  logic [A_WIDTH-1:0]         s1_a;
  logic [B_WIDTH-1:0]         s1_b;
  logic signed [P_WIDTH-1:0]  prod;

  assign advance = !vld_pipe[2] || bus.rsp_ready;

  // Masking the requests keeps req_ready low and ptr frozen while in reset.
  assign req_m = ap_rst ? '0 : bus.req_valid;

  cnn_mul_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .req     (req_m),
    .advance (advance),
    .grant   (grant)
  );

  assign bus.req_ready = advance ? grant : '0;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gidx = ID_WIDTH'(i);
  end

  // Both operands widened to P_WIDTH: a sign-extended, b zero-extended, so
  // the low P_WIDTH bits are the exact product. One multiply for DSP mapping.
  assign prod = $signed({{(P_WIDTH-A_WIDTH){s1_a[A_WIDTH-1]}}, s1_a}) *
                $signed({{(P_WIDTH-B_WIDTH){1'b0}}, s1_b});

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_pipe   <= '0;
      s1_id      <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      bus.rsp_id <= '0;
      bus.rsp_p  <= '0;
    end else if (advance) begin
      vld_pipe   <= {vld_pipe[1], |grant};
      s1_id      <= gidx;
      s1_a       <= bus.req_a[gidx*A_WIDTH +: A_WIDTH];
      s1_b       <= bus.req_b[gidx*B_WIDTH +: B_WIDTH];
      bus.rsp_id <= s1_id;
      bus.rsp_p  <= prod;
    end
  end

  assign bus.rsp_valid = vld_pipe[2];
  assign bus.idle      = ~|vld_pipe;
endmodule
